// File: rtl/fip_pkg.sv
// Shared Q16.16 fixed-point types, limits and the saturation helper
// used by the 3x3 determinant, divider and Cramer solver.
package fip_pkg;

  localparam int FIP_FRA_BITS = 16;

  typedef logic signed [31:0] fip_t;
  typedef fip_t [0:2] vec3_t;
  typedef vec3_t [0:2] mat3_t;

  localparam fip_t FIP_MIN = 32'sh80000000;
  localparam fip_t FIP_MAX = 32'sh7fffffff;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DIV,
    S_DONE
  } solve_state_t;

  // Clamp a wide signed intermediate into the 32-bit Q16.16 range.
  function automatic fip_t fip_sat(input logic signed [127:0] v);
    if (v > 128'(FIP_MAX)) return FIP_MAX;
    if (v < 128'(FIP_MIN)) return FIP_MIN;
    return $signed(v[31:0]);
  endfunction

endpackage

// File: rtl/fip_32_3b3_det.sv
// Pipelined 3x3 determinant in Q16.16; full-precision products, result
// saturated to 32 bits and delivered DET_LAT cycles after i_en.
module fip_32_3b3_det
  import fip_pkg::*;
#(
  parameter int FRA_BITS = FIP_FRA_BITS,
  parameter int DET_LAT  = 1
) (
  input  logic  i_clk,
  input  logic  i_rstn,
  input  logic  i_en,
  input  mat3_t i_matrix,
  output fip_t  o_det,
  output logic  o_valid
);

  function automatic logic signed [127:0] w(input fip_t v);
    return 128'(v);
  endfunction

  fip_t                  m [3][3];
  logic signed [127:0]   cof0, cof1, cof2, full;
  fip_t                  det_c;
  fip_t                  det_q [DET_LAT];
  logic                  vld_q [DET_LAT];

  // Products stay in Q48.48 until the single final shift back to Q16.16.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        m[r][c] = i_matrix[r][c];
      end
    end
    cof0  = w(m[1][1]) * w(m[2][2]) - w(m[1][2]) * w(m[2][1]);
    cof1  = w(m[1][0]) * w(m[2][2]) - w(m[1][2]) * w(m[2][0]);
    cof2  = w(m[1][0]) * w(m[2][1]) - w(m[1][1]) * w(m[2][0]);
    full  = w(m[0][0]) * cof0 - w(m[0][1]) * cof1 + w(m[0][2]) * cof2;
    det_c = fip_sat(full >>> (2 * FRA_BITS));
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int s = 0; s < DET_LAT; s++) begin
        det_q[s] <= '0;
        vld_q[s] <= 1'b0;
      end
    end else begin
      det_q[0] <= det_c;
      vld_q[0] <= i_en;
      for (int s = 1; s < DET_LAT; s++) begin
        det_q[s] <= det_q[s-1];
        vld_q[s] <= vld_q[s-1];
      end
    end
  end

  assign o_det   = det_q[DET_LAT-1];
  assign o_valid = vld_q[DET_LAT-1];

endmodule

// File: rtl/fip_32_col_subst.sv
// Combinational column substitution: returns A with column i_sel replaced
// by b; select 3 passes A through unchanged.
module fip_32_col_subst
  import fip_pkg::*;
(
  input  mat3_t      i_matrix,
  input  vec3_t      i_rhs,
  input  logic [1:0] i_sel,
  output mat3_t      o_matrix
);

  always_comb begin
    o_matrix = i_matrix;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (i_sel == 2'(c)) o_matrix[r][c] = i_rhs[r];
      end
    end
  end

endmodule

// File: rtl/fip_32_div.sv
// Combinational Q16.16 divide, truncating toward zero; with SAT set,
// overflow and division by zero clamp to FIP_MAX / FIP_MIN.
module fip_32_div
  import fip_pkg::*;
#(
  parameter int FRA_BITS = FIP_FRA_BITS,
  parameter int SAT      = 1
) (
  input  fip_t i_num,
  input  fip_t i_den,
  output fip_t o_quo
);

  logic signed [63:0] num_w, quo_w;

  always_comb begin
    num_w = 64'(i_num) <<< FRA_BITS;
    if (i_den == '0) quo_w = i_num[31] ? 64'(FIP_MIN) : 64'(FIP_MAX);
    else             quo_w = num_w / 64'(i_den);
    o_quo = (SAT != 0) ? fip_sat(128'(quo_w)) : $signed(quo_w[31:0]);
  end

endmodule

// File: rtl/fip_32_3b3_solve.sv
// Cramer's-rule 3x3 solver: four determinants through one shared det unit,
// then three quotients through one divider, one per cycle.
module fip_32_3b3_solve
  import fip_pkg::*;
#(
  parameter int FRA_BITS = FIP_FRA_BITS,
  parameter int DET_LAT  = 1
) (
  input  logic  i_clk,
  input  logic  i_rstn,
  input  logic  i_en,
  input  mat3_t i_matrix,
  input  vec3_t i_rhs,
  output vec3_t o_x,
  output logic  o_busy,
  output logic  o_valid,
  output logic  o_singular
);

  solve_state_t state_q;
  mat3_t        a_q;
  vec3_t        b_q;
  logic [1:0]   k_q;   // det issue index
  logic [1:0]   r_q;   // det result counter
  logic [1:0]   i_q;   // quotient index
  fip_t         d_q [4];
  vec3_t        x_q;
  logic         valid_q, sing_q;

  logic [1:0]   sel;
  mat3_t        det_mat;
  logic         det_en, det_vld;
  fip_t         det_out, div_num, quo;

  // Issue k=0 is plain A (select 3); k=1..3 substitute columns 0..2.
  assign sel    = k_q - 2'd1;
  assign det_en = (state_q == S_ISSUE);

  fip_32_col_subst u_subst (
    .i_matrix (a_q),
    .i_rhs    (b_q),
    .i_sel    (sel),
    .o_matrix (det_mat)
  );

  fip_32_3b3_det #(.FRA_BITS(FRA_BITS), .DET_LAT(DET_LAT)) u_det (
    .i_clk    (i_clk),
    .i_rstn   (i_rstn),
    .i_en     (det_en),
    .i_matrix (det_mat),
    .o_det    (det_out),
    .o_valid  (det_vld)
  );

  always_comb begin
    case (i_q)
      2'd0:    div_num = d_q[1];
      2'd1:    div_num = d_q[2];
      default: div_num = d_q[3];
    endcase
  end

  fip_32_div #(.FRA_BITS(FRA_BITS), .SAT(1)) u_div (
    .i_num (div_num),
    .i_den (d_q[0]),
    .o_quo (quo)
  );

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      r_q     <= '0;
      i_q     <= '0;
      for (int n = 0; n < 4; n++) d_q[n] <= '0;
      x_q     <= '0;
      valid_q <= 1'b0;
      sing_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if ((state_q == S_ISSUE || state_q == S_WAIT) && det_vld) begin
        d_q[r_q] <= det_out;
        r_q      <= r_q + 2'd1;
      end
      case (state_q)
        S_IDLE: begin
          if (i_en) begin
            a_q     <= i_matrix;
            b_q     <= i_rhs;
            k_q     <= '0;
            r_q     <= '0;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          k_q <= k_q + 2'd1;
          if (k_q == 2'd3) state_q <= S_WAIT;
        end
        S_WAIT: begin
          // The fourth determinant closes the set; D[0] is already held.
          if (det_vld && r_q == 2'd3) begin
            if (d_q[0] == '0) begin
              sing_q  <= 1'b1;
              x_q     <= '0;
              valid_q <= 1'b1;
              state_q <= S_DONE;
            end else begin
              sing_q  <= 1'b0;
              i_q     <= '0;
              state_q <= S_DIV;
            end
          end
        end
        S_DIV: begin
          x_q[i_q] <= quo;
          i_q      <= i_q + 2'd1;
          if (i_q == 2'd2) begin
            valid_q <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_x        = x_q;
  assign o_busy     = (state_q != S_IDLE);
  assign o_valid    = valid_q;
  assign o_singular = sing_q;

endmodule

// File: tb/tb_fip_32_3b3_solve.sv
// Directed and randomized bench for the Cramer solver; random cases use
// quarter-step integer matrices so the reference determinant is exact.
module tb_fip_32_3b3_solve;
  import fip_pkg::*;

  localparam int DET_LAT = 1;
  localparam int ONE     = 65536;

  logic  clk = 1'b0;
  logic  rstn;
  logic  en;
  mat3_t mat;
  vec3_t rhs;
  vec3_t x;
  logic  busy, valid, sing;

  int    checks = 0;
  int    errors = 0;
  vec3_t last_x;

  always #5 clk = ~clk;

  fip_32_3b3_solve #(.FRA_BITS(16), .DET_LAT(DET_LAT)) dut (
    .i_clk      (clk),
    .i_rstn     (rstn),
    .i_en       (en),
    .i_matrix   (mat),
    .i_rhs      (rhs),
    .o_x        (x),
    .o_busy     (busy),
    .o_valid    (valid),
    .o_singular (sing)
  );

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic mat3_t m9(input int a0, input int a1, input int a2,
                               input int a3, input int a4, input int a5,
                               input int a6, input int a7, input int a8);
    mat3_t m;
    m[0][0] = a0; m[0][1] = a1; m[0][2] = a2;
    m[1][0] = a3; m[1][1] = a4; m[1][2] = a5;
    m[2][0] = a6; m[2][1] = a7; m[2][2] = a8;
    return m;
  endfunction

  function automatic vec3_t v3(input int a, input int b, input int c);
    vec3_t v;
    v[0] = a; v[1] = b; v[2] = c;
    return v;
  endfunction

  // Rule of Sarrus on an integer matrix.
  function automatic longint sarrus(input longint m[3][3]);
    return m[0][0]*m[1][1]*m[2][2] + m[0][1]*m[1][2]*m[2][0] + m[0][2]*m[1][0]*m[2][1]
         - m[0][2]*m[1][1]*m[2][0] - m[0][0]*m[1][2]*m[2][1] - m[0][1]*m[1][0]*m[2][2];
  endfunction

  // Entries are counted in quarters: a det of quarter^3 units is det/64,
  // which in Q16.16 is det*1024. x_i = D_{i+1}/D_0, truncated, clamped.
  task automatic model(input int q[3][3], input int qb[3], output vec3_t ex, output logic exs);
    longint m[3][3];
    longint d[4];
    longint v;
    for (int k = 0; k < 4; k++) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          m[r][c] = (k > 0 && c == k - 1) ? longint'(qb[r]) : longint'(q[r][c]);
      d[k] = sarrus(m) * 1024;
    end
    ex  = '0;
    exs = (d[0] == 0);
    if (!exs) begin
      for (int i = 0; i < 3; i++) begin
        v = (d[i+1] * 65536) / d[0];
        if (v > 64'sh7fffffff) v = 64'sh7fffffff;
        if (v < -64'sh80000000) v = -64'sh80000000;
        ex[i] = fip_t'(v);
      end
    end
  endtask

  task automatic run_solve(input string tag, input mat3_t a, input vec3_t b,
                           input vec3_t ex, input logic exs, input int exlat);
    int  lat;
    bit  seen;
    lat  = -1;
    seen = 1'b0;
    @(negedge clk);
    mat = a; rhs = b; en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    for (int r = 0; r < 3; r++) begin
      rhs[r] = $urandom;
      for (int c = 0; c < 3; c++) mat[r][c] = $urandom;
    end
    for (int c = 1; c <= 60 && !seen; c++) begin
      @(negedge clk);
      if (c == 2) begin
        chk({tag, "_busy"}, 96'(busy), 96'(1));
        chk({tag, "_xhold"}, x, last_x);
      end
      if (valid) begin
        seen = 1'b1;
        lat  = c;
      end
    end
    chk({tag, "_lat"}, 96'(lat), 96'(exlat));
    chk({tag, "_x"}, x, ex);
    chk({tag, "_sing"}, 96'(sing), 96'(exs));
    @(negedge clk);
    chk({tag, "_pulse"}, 96'({valid, busy}), 96'(0));
    last_x = ex;
  endtask

  initial begin
    int    q[3][3];
    int    qb[3];
    mat3_t a;
    vec3_t b, ex;
    logic  exs;
    int    nvld, v1, v2, nidle, nbusy;

    rstn = 1'b0; en = 1'b0; mat = '0; rhs = '0; last_x = '0;
    repeat (3) @(negedge clk);
    chk("reset_out", 96'({x, busy, valid, sing}), 96'(0));
    rstn = 1'b1;

    run_solve("ident", m9(ONE,0,0, 0,ONE,0, 0,0,ONE), v3(ONE, 2*ONE, 3*ONE),
              v3(65536, 131072, 196608), 1'b0, 8 + DET_LAT);
    run_solve("diag2", m9(2*ONE,0,0, 0,2*ONE,0, 0,0,2*ONE), v3(ONE, ONE, ONE),
              v3(32768, 32768, 32768), 1'b0, 8 + DET_LAT);
    run_solve("diag241", m9(2*ONE,0,0, 0,4*ONE,0, 0,0,ONE), v3(-ONE, 2*ONE, 3*ONE),
              v3(-32768, 32768, 196608), 1'b0, 8 + DET_LAT);
    run_solve("sing", m9(ONE,2*ONE,3*ONE, 4*ONE,5*ONE,6*ONE, 7*ONE,8*ONE,9*ONE),
              v3(5*ONE, -7*ONE, 11), v3(0, 0, 0), 1'b1, 5 + DET_LAT);
    run_solve("satur", m9(16384,0,0, 0,16384,0, 0,0,16384), v3(FIP_MAX, FIP_MIN, ONE),
              v3(FIP_MAX, FIP_MIN, 262144), 1'b0, 8 + DET_LAT);

    for (int it = 0; it < 10; it++) begin
      for (int r = 0; r < 3; r++) begin
        qb[r] = int'($urandom_range(128)) - 64;
        for (int c = 0; c < 3; c++) q[r][c] = int'($urandom_range(32)) - 16;
      end
      if (it % 4 == 3) for (int c = 0; c < 3; c++) q[2][c] = q[0][c];
      for (int r = 0; r < 3; r++) begin
        b[r] = qb[r] * 16384;
        for (int c = 0; c < 3; c++) a[r][c] = q[r][c] * 16384;
      end
      model(q, qb, ex, exs);
      run_solve($sformatf("rnd%0d", it), a, b, ex, exs, exs ? 5 + DET_LAT : 8 + DET_LAT);
    end

    // i_en held high for 20 cycles: one solve per IDLE acceptance.
    @(negedge clk);
    mat = m9(ONE,0,0, 0,ONE,0, 0,0,ONE); rhs = v3(ONE, 2*ONE, 3*ONE); en = 1'b1;
    nvld = 0; v1 = -1; v2 = -1; nidle = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (c == 20) en = 1'b0;
      @(negedge clk);
      if (valid) begin
        nvld++;
        if (nvld == 1) v1 = c;
        if (nvld == 2) v2 = c;
        chk($sformatf("hold_x%0d", nvld), x, v3(65536, 131072, 196608));
      end
      if (!busy && c < 20) nidle++;
    end
    chk("hold_nvalid", 96'(nvld), 96'(2));
    chk("hold_v1", 96'(v1), 96'(8 + DET_LAT));
    chk("hold_v2", 96'(v2), 96'(17 + 2 * DET_LAT));
    chk("hold_idle", 96'(nidle), 96'(1));

    // Reset asserted in cycle 3 of a solve.
    @(negedge clk);
    mat = m9(2*ONE,0,0, 0,2*ONE,0, 0,0,2*ONE); rhs = v3(ONE, ONE, ONE); en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("rst_mid_out", 96'({x, busy, valid, sing}), 96'(0));
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    nvld = 0; nbusy = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (valid) nvld++;
      if (busy) nbusy++;
    end
    chk("rst_no_valid", 96'(nvld), 96'(0));
    chk("rst_no_busy", 96'(nbusy), 96'(0));
    last_x = '0;
    run_solve("post_rst", m9(ONE,0,0, 0,ONE,0, 0,0,ONE), v3(ONE, 2*ONE, 3*ONE),
              v3(65536, 131072, 196608), 1'b0, 8 + DET_LAT);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fip_32_3b3_solve.md
Name: fip_32_3b3_solve

Overview:
- Solves the 3x3 linear system A·x = b in Q16.16 fixed point using Cramer's rule.
- Sits directly downstream of fip_32_3b3_det, which it owns as a single time-multiplexed instance. Its three quotients come from fip_32_div.
- Used by the ray–triangle intersection stage to recover (t, u, v) from edge/ray vectors.

Parameters:
- FRA_BITS, 16, number of fractional bits (Q16.16); passed to the divider.
- DET_LAT, 1, en-to-valid latency of fip_32_3b3_det; used only for the latency statement and the bench.

Ports:
- i_clk  in  1  clock.
- i_rstn  in  1  asynchronous active-low reset.
- i_en  in  1  start request; sampled only in IDLE.
- i_matrix  in  32 x [0:2][0:2]  signed A, row-major, Q16.16.
- i_rhs  in  32 x [0:2]  signed b, Q16.16.
- o_x  out  32 x [0:2]  signed solution, Q16.16.
- o_busy  out  1  high from the cycle after acceptance until o_valid deasserts.
- o_valid  out  1  one-cycle pulse; o_x and o_singular are valid.
- o_singular  out  1  det(A) == 0 for the current result.

Behaviour:
- Reset (async, i_rstn=0):
  - state=IDLE; o_x={0,0,0}; o_busy=0; o_valid=0; o_singular=0.
  - Result counter and det registers cleared.
  - Det instance shares i_rstn.
- States: IDLE -> ISSUE -> WAIT -> DIV -> DONE -> IDLE.
- Cycle 0, IDLE with i_en=1:
  - Register i_matrix and i_rhs; go to ISSUE.
  - i_en=0 stays in IDLE.
- ISSUE, cycles 1..4: drive the det unit with en=1 and issue index k=0..3.
  - k=0: A.
  - k=1: A with column 0 replaced by b.
  - k=2: A with column 1 replaced by b.
  - k=3: A with column 2 replaced by b.
  - After k=3, go to WAIT (det en=0).
- Collection:
  - Each det o_valid captures o_det into D[r], r = 2-bit result counter (0..3), then r++.
  - Capture is active in ISSUE and WAIT; the WAIT-phase capture of r=3 completes the set.
  - If DET_LAT makes results arrive during ISSUE, they are still captured in order.
- After D[3] is captured (edge closing cycle 4+DET_LAT):
  - If D[0]==0: o_singular=1, o_x={0,0,0}, go to DONE.
  - Otherwise: o_singular=0, go to DIV.
- DIV, 3 cycles:
  - One combinational fip_32_div (SAT=1) computes D[i+1]/D[0] for i=0,1,2.
  - Result is registered into o_x[i] at each edge.
  - Overflow or underflow saturates to FIP_MAX / FIP_MIN.
- DONE, 1 cycle: o_valid=1, then return to IDLE.
- Latency from acceptance (cycle 0):
  - Non-singular: o_valid in cycle 8+DET_LAT.
  - Singular: o_valid in cycle 5+DET_LAT.
- Busy and hold rules:
  - o_busy=1 in ISSUE, WAIT, DIV and DONE.
  - i_en is ignored whenever state != IDLE; no queuing.
  - i_matrix and i_rhs may change after cycle 0 without effect.
- o_x and o_singular hold their last values until overwritten by the next result or reset. o_x is not cleared on a new start until DIV/DONE writes it.
- Reset mid-operation: immediate return to IDLE with reset values; no o_valid pulse; in-flight det results are discarded.
- Back-to-back: a new i_en may be accepted in the IDLE cycle immediately after DONE.
- Arithmetic: all values signed 32-bit Q16.16. No internal widening beyond what the det and div units do.

Decomposition:
- Shared package fip_pkg:
  - FRA_BITS default; FIP_MIN = 32'sh80000000; FIP_MAX = 32'sh7fffffff.
  - typedef fip_t (logic signed [31:0]); vec3_t (fip_t [0:2]); mat3_t (fip_t [0:2][0:2]).
  - Enum solve_state_t.
- Sub-module fip_32_col_subst: combinational; given A, b and a 2-bit column select, returns A with the selected column replaced by b (select 3 = pass A). Used to build the det operand in ISSUE.

Test Plan:
- Identity A, b=(1,2,3)<<16, i_en pulse:
  - o_valid at cycle 8+DET_LAT.
  - o_x=(65536,131072,196608); o_singular=0.
- A=diag(2,2,2)<<16, b=(1,1,1)<<16:
  - o_x=(32768,32768,32768).
  - A=diag(2,4,1)<<16, b=(-1,2,3)<<16 -> o_x=(-32768,32768,196608).
- A=[[1,2,3],[4,5,6],[7,8,9]]<<16, any b:
  - o_singular=1; o_x=(0,0,0); o_valid at cycle 5+DET_LAT.
- A=diag(0.25)=16384 each, b=(FIP_MAX, FIP_MIN, 1<<16):
  - o_x=(FIP_MAX, FIP_MIN, 262144).
- Hold i_en=1 for 20 cycles with the identity case:
  - Exactly one solve per IDLE acceptance; o_busy high between them.
  - Second result starts the cycle after DONE.
- Assert i_rstn=0 in cycle 3 of a solve:
  - All outputs 0 and no o_valid pulse.
  - A fresh solve after release returns the correct identity result.
